// File: rtl/wb_regfile_if.sv
// Writeback-stage bus for wb_regfile: MEM/WB pipeline inputs, decode read
// ports, and the commit/retire trace outputs.
interface wb_regfile_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int ISIZE = 16
);
  logic [DSIZE-1:0] readData_wb;
  logic [DSIZE-1:0] alu_wb;
  logic [ASIZE-1:0] waddr_wb;
  logic             wen_wb;
  logic             memtoReg_wb;
  logic             jal_wb;
  logic [ISIZE-1:0] pc_wb;
  logic [ASIZE-1:0] raddr1;
  logic [ASIZE-1:0] raddr2;
  logic [DSIZE-1:0] rdata1;
  logic [DSIZE-1:0] rdata2;
  logic [DSIZE-1:0] wb_data;
  logic             commit_valid;
  logic [ASIZE-1:0] commit_addr;
  logic [DSIZE-1:0] commit_data;
  logic [15:0]      retire_count;

  modport master (
    output readData_wb, alu_wb, waddr_wb, wen_wb, memtoReg_wb, jal_wb, pc_wb,
           raddr1, raddr2,
    input  rdata1, rdata2, wb_data, commit_valid, commit_addr, commit_data,
           retire_count
  );

  modport slave (
    input  readData_wb, alu_wb, waddr_wb, wen_wb, memtoReg_wb, jal_wb, pc_wb,
           raddr1, raddr2,
    output rdata1, rdata2, wb_data, commit_valid, commit_addr, commit_data,
           retire_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and register file: source select, write-through read ports,
// and a commit trace with a wrapping retire counter.
module wb_regfile #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int ISIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  wb_regfile_if.slave bus
);

  localparam int unsigned NREG = 1 << ASIZE;

  logic [DSIZE-1:0] regs [NREG];
  logic [DSIZE-1:0] link_val;
  logic [DSIZE-1:0] sel_data;
  logic             accept;
  logic             commit_valid_q;
  logic [ASIZE-1:0] commit_addr_q;
  logic [DSIZE-1:0] commit_data_q;
  logic [15:0]      retire_q;

  always_comb begin
    link_val = '0;
    link_val[ISIZE-1:0] = bus.pc_wb;
  end

  always_comb begin
    sel_data = bus.alu_wb;
    if (bus.jal_wb)
      sel_data = link_val;
    else if (bus.memtoReg_wb)
      sel_data = bus.readData_wb;
  end

  // Reset gates acceptance, so it also suppresses the read bypass.
  assign accept = bus.wen_wb && (bus.waddr_wb != '0) && !rst;

  always_comb begin
    bus.rdata1 = (bus.raddr1 == '0) ? '0 : regs[bus.raddr1];
    if (accept && (bus.raddr1 == bus.waddr_wb))
      bus.rdata1 = sel_data;
  end

  always_comb begin
    bus.rdata2 = (bus.raddr2 == '0) ? '0 : regs[bus.raddr2];
    if (accept && (bus.raddr2 == bus.waddr_wb))
      bus.rdata2 = sel_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
      commit_valid_q <= 1'b0;
      commit_addr_q  <= '0;
      commit_data_q  <= '0;
      retire_q       <= '0;
    end else begin
      commit_valid_q <= accept;
      if (accept) begin
        regs[bus.waddr_wb] <= sel_data;
        commit_addr_q      <= bus.waddr_wb;
        commit_data_q      <= sel_data;
        retire_q           <= retire_q + 16'd1;
      end
    end
  end

  assign bus.wb_data      = sel_data;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_addr  = commit_addr_q;
  assign bus.commit_data  = commit_data_q;
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with hand-computed expected values.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  wb_regfile_if #(.DSIZE(16), .ASIZE(4), .ISIZE(16)) bus ();

  wb_regfile #(.DSIZE(16), .ASIZE(4), .ISIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge and are held through the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.readData_wb = '0; bus.alu_wb = '0; bus.waddr_wb = '0; bus.wen_wb = 1'b0;
    bus.memtoReg_wb = 1'b0; bus.jal_wb = 1'b0; bus.pc_wb = '0;
    bus.raddr1 = 4'd3; bus.raddr2 = 4'd0;
    tick(); tick();
    check("rst_cvalid", 32'(bus.commit_valid), 32'h0);
    check("rst_caddr",  32'(bus.commit_addr),  32'h0);
    check("rst_cdata",  32'(bus.commit_data),  32'h0);
    check("rst_retire", 32'(bus.retire_count), 32'h0);
    check("rst_r3",     32'(bus.rdata1),       32'h0);

    // First cycle after reset release writes R3 = 0x1234 from the ALU.
    rst = 1'b0;
    bus.wen_wb = 1'b1; bus.waddr_wb = 4'd3; bus.alu_wb = 16'h1234;
    #1;
    check("w3_wbdata", 32'(bus.wb_data), 32'h1234);
    check("w3_bypass", 32'(bus.rdata1),  32'h1234);
    check("w3_r0",     32'(bus.rdata2),  32'h0);
    tick();
    bus.wen_wb = 1'b0;
    #1;
    check("w3_stored", 32'(bus.rdata1),       32'h1234);
    check("w3_cvalid", 32'(bus.commit_valid), 32'h1);
    check("w3_caddr",  32'(bus.commit_addr),  32'h3);
    check("w3_cdata",  32'(bus.commit_data),  32'h1234);
    check("w3_retire", 32'(bus.retire_count), 32'h1);
    tick();
    check("idle_cvalid", 32'(bus.commit_valid), 32'h0);
    check("idle_caddr",  32'(bus.commit_addr),  32'h3);

    // Memory-sourced write to R5 with both ports bypassing.
    bus.wen_wb = 1'b1; bus.waddr_wb = 4'd5; bus.memtoReg_wb = 1'b1;
    bus.readData_wb = 16'hBEEF; bus.alu_wb = 16'h1111;
    bus.raddr1 = 4'd5; bus.raddr2 = 4'd5;
    #1;
    check("byp_rd1", 32'(bus.rdata1), 32'hBEEF);
    check("byp_rd2", 32'(bus.rdata2), 32'hBEEF);
    tick();
    bus.wen_wb = 1'b0; bus.raddr2 = 4'd3;
    #1;
    check("r5_stored", 32'(bus.rdata1),       32'hBEEF);
    check("r3_port2",  32'(bus.rdata2),       32'h1234);
    check("r5_retire", 32'(bus.retire_count), 32'h2);

    // Jump-and-link overrides both data sources.
    bus.jal_wb = 1'b1; bus.wen_wb = 1'b1; bus.waddr_wb = 4'd15; bus.pc_wb = 16'h0042;
    bus.alu_wb = 16'hFFFF; bus.memtoReg_wb = 1'b1; bus.readData_wb = 16'h7777;
    bus.raddr1 = 4'd15;
    #1;
    check("jal_wbdata", 32'(bus.wb_data), 32'h0042);
    tick();
    bus.wen_wb = 1'b0; bus.pc_wb = 16'h0099;
    #1;
    check("jal_r15",    32'(bus.rdata1),       32'h0042);
    check("jal_retire", 32'(bus.retire_count), 32'h3);
    tick();
    check("jal_nowen_r15",    32'(bus.rdata1),       32'h0042);
    check("jal_nowen_retire", 32'(bus.retire_count), 32'h3);
    check("jal_nowen_cvalid", 32'(bus.commit_valid), 32'h0);
    bus.jal_wb = 1'b0; bus.memtoReg_wb = 1'b0;

    // Writes to R0 are discarded and not counted.
    bus.wen_wb = 1'b1; bus.waddr_wb = 4'd0; bus.alu_wb = 16'h5555; bus.raddr1 = 4'd0;
    #1;
    check("r0_bypass", 32'(bus.rdata1), 32'h0);
    tick();
    bus.wen_wb = 1'b0;
    #1;
    check("r0_read",   32'(bus.rdata1),       32'h0);
    check("r0_cvalid", 32'(bus.commit_valid), 32'h0);
    check("r0_retire", 32'(bus.retire_count), 32'h3);
    check("r0_cdata",  32'(bus.commit_data),  32'h0042);

    // Unknown data/address with write disabled must not disturb state.
    bus.waddr_wb = 'x; bus.alu_wb = 'x; bus.readData_wb = 'x; bus.raddr1 = 4'd3;
    tick();
    check("x_r3",     32'(bus.rdata1),       32'h1234);
    check("x_retire", 32'(bus.retire_count), 32'h3);
    bus.readData_wb = '0;

    // Reset wins over a coincident write; bypass is suppressed during reset.
    rst = 1'b1; bus.wen_wb = 1'b1; bus.waddr_wb = 4'd7; bus.alu_wb = 16'h00AA;
    bus.raddr1 = 4'd7; bus.raddr2 = 4'd3;
    #1;
    check("rstw_nobyp",  32'(bus.rdata1),  32'h0);
    check("rstw_wbdata", 32'(bus.wb_data), 32'h00AA);
    tick();
    rst = 1'b0; bus.wen_wb = 1'b0;
    #1;
    check("rstw_r7",     32'(bus.rdata1),       32'h0);
    check("rstw_r3",     32'(bus.rdata2),       32'h0);
    check("rstw_retire", 32'(bus.retire_count), 32'h0);
    check("rstw_cvalid", 32'(bus.commit_valid), 32'h0);

    // 65535 back-to-back writes to R1, then one more wraps the counter.
    bus.wen_wb = 1'b1; bus.waddr_wb = 4'd1; bus.raddr1 = 4'd1;
    for (int i = 0; i < 65535; i++) begin
      bus.alu_wb = 16'(i);
      tick();
    end
    bus.wen_wb = 1'b0;
    #1;
    check("pre_wrap_retire", 32'(bus.retire_count), 32'hFFFF);
    check("pre_wrap_r1",     32'(bus.rdata1),       32'hFFFE);
    bus.wen_wb = 1'b1; bus.alu_wb = 16'hABCD;
    tick();
    bus.wen_wb = 1'b0;
    #1;
    check("wrap_retire", 32'(bus.retire_count), 32'h0);
    check("wrap_cvalid", 32'(bus.commit_valid), 32'h1);
    check("wrap_r1",     32'(bus.rdata1),       32'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DSIZE, default 16, data word width.
REQ-002 Parameter ASIZE, default 4, register address width (2^ASIZE registers).
REQ-003 Parameter ISIZE, default 16, PC width; ISIZE <= DSIZE.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 readData_wb  input  DSIZE  registered data-memory read value from the MEM/WB register.
REQ-007 alu_wb  input  DSIZE  registered ALU result from the MEM/WB register.
REQ-008 waddr_wb  input  ASIZE  destination register from the MEM/WB register.
REQ-009 wen_wb  input  1  register write enable from the MEM/WB register.
REQ-010 memtoReg_wb  input  1  1 selects readData_wb, 0 selects alu_wb.
REQ-011 jal_wb  input  1  jump-and-link; selects the link value over both data sources.
REQ-012 pc_wb  input  ISIZE  return PC carried through MEM/WB, already incremented upstream.
REQ-013 raddr1, raddr2  input  ASIZE  each; decode-stage read addresses.
REQ-014 rdata1, rdata2  output  DSIZE  each; combinational read data.
REQ-015 wb_data  output  DSIZE  combinational selected writeback value, for EX/MEM forwarding.
REQ-016 commit_valid  output  1  registered; high for one cycle after each accepted write.
REQ-017 commit_addr  output  ASIZE  registered address of the last accepted write.
REQ-018 commit_data  output  DSIZE  registered value of the last accepted write.
REQ-019 retire_count  output  16  registered count of accepted writes.

Function
REQ-020 wb_data SHALL be {zero-extend(pc_wb)} if jal_wb=1, else readData_wb if memtoReg_wb=1, else alu_wb.
REQ-021 A write SHALL be accepted when wen_wb=1 and waddr_wb!=0; register waddr_wb takes wb_data at the next rising edge.
REQ-022 Register 0 SHALL read as 0 always; writes to address 0 SHALL be discarded and SHALL NOT be counted.
REQ-023 jal_wb=1 with wen_wb=0 SHALL NOT write; jal is a source select only.
REQ-024 rdataN SHALL equal wb_data when the write is accepted in the same cycle and raddrN==waddr_wb (write-through bypass); otherwise the stored register value.
REQ-025 Both read ports SHALL bypass independently; raddr1==raddr2 SHALL return identical data.
REQ-026 commit_valid SHALL be 1 in the cycle after an accepted write, else 0; commit_addr/commit_data SHALL update only on accepted writes and hold otherwise.
REQ-027 retire_count SHALL increment by 1 on each accepted write, wrapping 0xFFFF -> 0x0000 with no flag.
REQ-028 Write latency SHALL be one clock: a value written at edge N is visible un-bypassed from cycle N onward.
REQ-029 Unknown inputs with wen_wb=0 SHALL NOT alter any stored state.

Reset
REQ-030 With rst=1 at a rising edge, all registers SHALL become 0, commit_valid 0, commit_addr 0, commit_data 0, retire_count 0.
REQ-031 rst SHALL take precedence over a simultaneous accepted write; that write SHALL be lost and not counted.
REQ-032 rdata/wb_data SHALL remain combinational during reset; bypass SHALL be suppressed while rst=1 (rdataN returns stored value).
REQ-033 Release of rst SHALL allow a write in the first cycle after deassertion.

Verification
REQ-034 Reset, then wen=1, waddr=3, memtoReg=0, alu=0x1234 -> next cycle rdata1(raddr1=3)=0x1234, commit_valid=1, commit_addr=3, retire_count=1.
REQ-035 Same-cycle bypass: wen=1, waddr=5, memtoReg=1, readData=0xBEEF, raddr1=raddr2=5 -> rdata1=rdata2=0xBEEF in that cycle before the edge.
REQ-036 jal=1, wen=1, waddr=15, pc=0x0042, alu=0xFFFF -> R15=0x0042; jal=1, wen=0 -> R15 unchanged, retire_count unchanged.
REQ-037 wen=1, waddr=0, alu=0x5555 -> rdata1(raddr1=0)=0, commit_valid=0, retire_count unchanged.
REQ-038 Preload retire_count to 0xFFFF via 65535 writes, one more write -> retire_count=0x0000.
REQ-039 rst=1 coincident with wen=1, waddr=7, alu=0x00AA -> R7=0, retire_count=0, commit_valid=0 after the edge.
